// File: rtl/np2_pkg.sv
// Shared helpers for the algorithmic memory wrappers: log2, power-of-two test,
// and the geometry legality check applied at elaboration.
package np2_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Geometry must tile exactly and every width must match the counts it carries.
  function automatic bit np2_params_ok(input int numaddr, input int bitaddr,
                                       input int numvbnk, input int bitvbnk,
                                       input int numvrow, input int bitvrow);
    return (numvbnk >= 1) && (numvrow >= 1) &&
           (numvbnk * numvrow == numaddr) &&
           (bitaddr >= clog2(numaddr)) &&
           (bitvbnk == clog2(numvbnk)) &&
           (bitvrow == clog2(numvrow));
  endfunction

endpackage

// File: rtl/np2_divmod.sv
// Combinational quotient/remainder by a constant divisor; power-of-two
// divisors reduce to shifting and masking.
module np2_divmod
  import np2_pkg::*;
#(
  parameter int W   = 4,
  parameter int DIV = 3,
  parameter int QW  = 2,
  parameter int RW  = 2
) (
  input  logic [W-1:0]  i_num,
  output logic [QW-1:0] o_quo,
  output logic [RW-1:0] o_rem
);

  localparam int LOG = clog2(DIV);

  logic [W-1:0] w_quo_full;
  logic [W-1:0] w_rem_full;

  generate
    if (is_pow2(DIV)) begin : g_pow2
      localparam logic [W-1:0] MASK = W'((64'd1 << LOG) - 64'd1);
      assign w_quo_full = i_num >> LOG;
      assign w_rem_full = i_num & MASK;
    end else begin : g_const
      localparam logic [W-1:0] DIV_W = W'(DIV);
      assign w_quo_full = i_num / DIV_W;
      assign w_rem_full = i_num % DIV_W;
    end
  endgenerate

  assign o_quo = w_quo_full[QW-1:0];
  assign o_rem = w_rem_full[RW-1:0];

endmodule

// File: rtl/np2_addr_split.sv
// Registered virtual-address splitter: bank = vaddr mod NUMVBNK,
// row = vaddr div NUMVBNK, with out-of-range detection and one cycle of latency.
module np2_addr_split
  import np2_pkg::*;
#(
  parameter int NUMADDR = 16,
  parameter int BITADDR = 4,
  parameter int NUMVBNK = 4,
  parameter int BITVBNK = 2,
  parameter int NUMVROW = 4,
  parameter int BITVROW = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   vld,
  input  logic [BITADDR-1:0]                     vaddr,
  output logic                                   vld_out,
  output logic [((BITVBNK > 0) ? BITVBNK : 1)-1:0] vbadr,
  output logic [((BITVROW > 0) ? BITVROW : 1)-1:0] vradr,
  output logic                                   addr_err
);

  localparam int VBW = (BITVBNK > 0) ? BITVBNK : 1;
  localparam int VRW = (BITVROW > 0) ? BITVROW : 1;
  localparam logic [BITADDR:0] NUMADDR_EXT = (BITADDR + 1)'(NUMADDR);

  generate
    if (!np2_params_ok(NUMADDR, BITADDR, NUMVBNK, BITVBNK, NUMVROW, BITVROW)) begin : g_bad_params
      $fatal(1, "np2_addr_split: illegal geometry NUMADDR=%0d NUMVBNK=%0d NUMVROW=%0d",
             NUMADDR, NUMVBNK, NUMVROW);
    end
  endgenerate

  logic [VRW-1:0] w_quo;
  logic [VBW-1:0] w_rem;
  logic [VRW-1:0] w_row;
  logic           w_oob;

  np2_divmod #(
    .W  (BITADDR),
    .DIV(NUMVBNK),
    .QW (VRW),
    .RW (VBW)
  ) u_divmod (
    .i_num(vaddr),
    .o_quo(w_quo),
    .o_rem(w_rem)
  );

  // One extra bit so NUMADDR == 2**BITADDR compares correctly.
  assign w_oob = ({1'b0, vaddr} >= NUMADDR_EXT);
  assign w_row = (NUMVROW == 1) ? {VRW{1'b0}} : w_quo;

  logic           r_vld_out;
  logic           r_addr_err;
  logic [VBW-1:0] r_vbadr;
  logic [VRW-1:0] r_vradr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_out  <= 1'b0;
      r_addr_err <= 1'b0;
      r_vbadr    <= {VBW{1'b0}};
      r_vradr    <= {VRW{1'b0}};
    end else begin
      r_vld_out  <= vld;
      r_addr_err <= vld & w_oob;
      if (vld && w_oob) begin
        r_vbadr <= {VBW{1'b0}};
        r_vradr <= {VRW{1'b0}};
      end else begin
        r_vbadr <= w_rem;
        r_vradr <= w_row;
      end
    end
  end

  assign vld_out  = r_vld_out;
  assign addr_err = r_addr_err;
  assign vbadr    = r_vbadr;
  assign vradr    = r_vradr;

endmodule

// File: tb/tb_np2_addr_split.sv
// Scoreboard bench: three geometries (16=4x4, 15=3x5, 4=1x4) driven in parallel,
// each checked against an arithmetic mod/div reference model.
module tb_np2_addr_split;

  typedef struct {
    bit v;
    bit e;
    int b;
    int r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [3:0] vaddr_a;
  logic [3:0] vaddr_b;
  logic [1:0] vaddr_c;

  logic       vld_out_a, addr_err_a;
  logic [1:0] vbadr_a, vradr_a;
  logic       vld_out_b, addr_err_b;
  logic [1:0] vbadr_b;
  logic [2:0] vradr_b;
  logic       vld_out_c, addr_err_c;
  logic [0:0] vbadr_c;
  logic [1:0] vradr_c;

  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;

  np2_addr_split #(.NUMADDR(16), .BITADDR(4), .NUMVBNK(4), .BITVBNK(2), .NUMVROW(4), .BITVROW(2)) u_a (
    .clk(clk), .rst(rst), .vld(vld), .vaddr(vaddr_a),
    .vld_out(vld_out_a), .vbadr(vbadr_a), .vradr(vradr_a), .addr_err(addr_err_a));

  np2_addr_split #(.NUMADDR(15), .BITADDR(4), .NUMVBNK(3), .BITVBNK(2), .NUMVROW(5), .BITVROW(3)) u_b (
    .clk(clk), .rst(rst), .vld(vld), .vaddr(vaddr_b),
    .vld_out(vld_out_b), .vbadr(vbadr_b), .vradr(vradr_b), .addr_err(addr_err_b));

  np2_addr_split #(.NUMADDR(4), .BITADDR(2), .NUMVBNK(1), .BITVBNK(0), .NUMVROW(4), .BITVROW(2)) u_c (
    .clk(clk), .rst(rst), .vld(vld), .vaddr(vaddr_c),
    .vld_out(vld_out_c), .vbadr(vbadr_c), .vradr(vradr_c), .addr_err(addr_err_c));

  function automatic exp_t ref_map(input bit r_in, input bit v_in, input int a,
                                   input int na, input int nb, input int nr, input int rbits);
    exp_t x;
    x.v = 1'b0; x.e = 1'b0; x.b = 0; x.r = 0;
    if (!r_in) begin
      x.v = v_in;
      x.e = v_in && (a >= na);
      if (!x.e) begin
        x.b = a % nb;
        x.r = (nr == 1) ? 0 : ((a / nb) % (1 << rbits));
      end
    end
    return x;
  endfunction

  task automatic cmp(input string nm, input exp_t x, input bit v, input bit e, input int b, input int r);
    checks++;
    if (v !== x.v || e !== x.e || b != x.b || r != x.r) begin
      errors++;
      $display("FAIL %s: got vld_out=%0d addr_err=%0d vbadr=%0d vradr=%0d, want %0d %0d %0d %0d @%0t",
               nm, v, e, b, r, x.v, x.e, x.b, x.r, $time);
    end
  endtask

  // Expected responses are recorded at the edge where the DUTs sample their inputs.
  always @(posedge clk) begin
    if (started) begin
      q_a.push_back(ref_map(rst, vld, int'(vaddr_a), 16, 4, 4, 2));
      q_b.push_back(ref_map(rst, vld, int'(vaddr_b), 15, 3, 5, 3));
      q_c.push_back(ref_map(rst, vld, int'(vaddr_c), 4, 1, 4, 2));
    end
  end

  // Monitor: compare registered outputs half a cycle after each edge.
  always @(negedge clk) begin
    if (q_a.size() > 0) cmp("cfg16x4", q_a.pop_front(), vld_out_a, addr_err_a, int'(vbadr_a), int'(vradr_a));
    if (q_b.size() > 0) cmp("cfg15x3", q_b.pop_front(), vld_out_b, addr_err_b, int'(vbadr_b), int'(vradr_b));
    if (q_c.size() > 0) cmp("cfg4x1",  q_c.pop_front(), vld_out_c, addr_err_c, int'(vbadr_c), int'(vradr_c));
  end

  task automatic step(input bit r_in, input bit v_in, input int a, input int b, input int c);
    @(negedge clk);
    rst     = r_in;
    vld     = v_in;
    vaddr_a = 4'(a);
    vaddr_b = 4'(b);
    vaddr_c = 2'(c);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b1; vaddr_a = 4'd9; vaddr_b = 4'd7; vaddr_c = 2'd2;
    started = 1'b1;
    step(1'b1, 1'b1, 5, 5, 1);
    step(1'b0, 1'b1, 13, 14, 3);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 15 - i, i, i % 4);
    step(1'b0, 1'b1, 15, 15, 3);
    step(1'b0, 1'b0, 15, 15, 0);
    // Mid-stream reset kills the in-flight result.
    step(1'b0, 1'b1, 6, 8, 1);
    step(1'b0, 1'b1, 7, 11, 2);
    step(1'b1, 1'b1, 12, 13, 3);
    step(1'b0, 1'b1, 3, 4, 0);
    step(1'b0, 1'b1, 10, 2, 1);
    for (int i = 0; i < 300; i++)
      step(($urandom % 40) == 0, ($urandom % 4) != 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    @(negedge clk);
    started = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
